// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer so that IF can keep
// streaming while ID stalls. All outputs are driven from registered state.
module if_id_skid #(
   parameter int unsigned          CPU_WIDTH  = 16,
   parameter int unsigned          ADDR_WIDTH = 16,
   parameter logic [CPU_WIDTH-1:0] NOP_INST   = {CPU_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  hold_flag,
   input  logic                  if_valid,
   output logic                  if_ready,
   input  logic [ADDR_WIDTH-1:0] if_pc,
   input  logic [CPU_WIDTH-1:0]  if_inst,
   input  logic                  if_fault,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [ADDR_WIDTH-1:0] id_pc,
   output logic [CPU_WIDTH-1:0]  id_inst,
   output logic                  id_fault,
   output logic [1:0]            occupancy
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
   logic [CPU_WIDTH-1:0]    head_inst_q, head_inst_d, skid_inst_q, skid_inst_d;
   logic                    head_fault_q, head_fault_d, skid_fault_q, skid_fault_d;
   logic                    accept, consume;

   assign accept  = if_valid & (state_q != FULL);
   assign consume = (state_q != EMPTY) & id_ready & ~hold_flag;

   always_comb begin
      state_d      = state_q;
      head_pc_d    = head_pc_q;
      head_inst_d  = head_inst_q;
      head_fault_d = head_fault_q;
      skid_pc_d    = skid_pc_q;
      skid_inst_d  = skid_inst_q;
      skid_fault_d = skid_fault_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  head_pc_d    = if_pc;
                  head_inst_d  = if_inst;
                  head_fault_d = if_fault;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  head_pc_d    = if_pc;
                  head_inst_d  = if_inst;
                  head_fault_d = if_fault;
               end else if (accept) begin
                  skid_pc_d    = if_pc;
                  skid_inst_d  = if_inst;
                  skid_fault_d = if_fault;
                  state_d      = FULL;
               end else if (consume) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (consume) begin
                  head_pc_d    = skid_pc_q;
                  head_inst_d  = skid_inst_q;
                  head_fault_d = skid_fault_q;
                  state_d      = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         head_pc_q    <= '0;
         head_inst_q  <= NOP_INST;
         head_fault_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_inst_q  <= '0;
         skid_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_pc_q    <= head_pc_d;
         head_inst_q  <= head_inst_d;
         head_fault_q <= head_fault_d;
         skid_pc_q    <= skid_pc_d;
         skid_inst_q  <= skid_inst_d;
         skid_fault_q <= skid_fault_d;
      end
   end

   assign if_ready  = (state_q != FULL);
   assign id_valid  = (state_q != EMPTY);
   assign id_pc     = head_pc_q;
   assign id_inst   = id_valid ? head_inst_q : NOP_INST;
   assign id_fault  = id_valid & head_fault_q;
   assign occupancy = state_q;

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: streaming, backpressure, hold, flush,
// fault tagging and asynchronous reset, each with hand-computed expectations.
module tb_if_id_skid;

   localparam logic [15:0] NOP = 16'h0013;

   logic        clk = 1'b0;
   logic        rst_n, flush, hold_flag, if_valid, if_fault, id_ready;
   logic        if_ready, id_valid, id_fault;
   logic [15:0] if_pc, if_inst, id_pc, id_inst;
   logic [1:0]  occupancy;
   int          total = 0;
   int          bad   = 0;

   if_id_skid #(
      .CPU_WIDTH (16),
      .ADDR_WIDTH(16),
      .NOP_INST  (NOP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .hold_flag(hold_flag),
      .if_valid (if_valid),
      .if_ready (if_ready),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .if_fault (if_fault),
      .id_valid (id_valid),
      .id_ready (id_ready),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .id_fault (id_fault),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic offer(input logic v, input logic [15:0] pc, input logic [15:0] inst,
                        input logic f);
      if_valid = v;
      if_pc    = pc;
      if_inst  = inst;
      if_fault = f;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".if_ready"}, 32'(if_ready), 32'd1);
      chk({tag, ".id_valid"}, 32'(id_valid), 32'd0);
      chk({tag, ".id_pc"}, 32'(id_pc), 32'd0);
      chk({tag, ".id_inst"}, 32'(id_inst), 32'(NOP));
      chk({tag, ".id_fault"}, 32'(id_fault), 32'd0);
      chk({tag, ".occ"}, 32'(occupancy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; hold_flag = 1'b0; id_ready = 1'b0;
      offer(1'b0, 16'h0, 16'h0, 1'b0);
      #1;
      chk_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // streaming
      id_ready = 1'b1;
      offer(1'b1, 16'h0000, 16'hA000, 1'b0);
      cyc();
      chk("str0.valid", 32'(id_valid), 32'd1);
      chk("str0.pc", 32'(id_pc), 32'h0000);
      chk("str0.occ", 32'(occupancy), 32'd1);
      offer(1'b1, 16'h0002, 16'hA002, 1'b0);
      cyc();
      chk("str1.pc", 32'(id_pc), 32'h0002);
      chk("str1.occ", 32'(occupancy), 32'd1);
      offer(1'b1, 16'h0004, 16'hA004, 1'b0);
      cyc();
      chk("str2.pc", 32'(id_pc), 32'h0004);
      chk("str2.inst", 32'(id_inst), 32'hA004);
      offer(1'b0, 16'h0, 16'h0, 1'b0);
      cyc();
      chk("drain.valid", 32'(id_valid), 32'd0);
      chk("drain.inst", 32'(id_inst), 32'(NOP));
      chk("drain.pc_kept", 32'(id_pc), 32'h0004);

      // backpressure
      id_ready = 1'b0;
      offer(1'b1, 16'h0010, 16'h1111, 1'b0);
      cyc();
      offer(1'b1, 16'h0012, 16'h2222, 1'b0);
      cyc();
      chk("bp.occ", 32'(occupancy), 32'd2);
      chk("bp.if_ready", 32'(if_ready), 32'd0);
      chk("bp.inst", 32'(id_inst), 32'h1111);
      offer(1'b1, 16'h0014, 16'h3333, 1'b0);
      cyc();
      chk("bp.full_hold.inst", 32'(id_inst), 32'h1111);
      chk("bp.full_hold.occ", 32'(occupancy), 32'd2);
      offer(1'b0, 16'h0, 16'h0, 1'b0);
      id_ready = 1'b1;
      cyc();
      chk("bp.second.inst", 32'(id_inst), 32'h2222);
      chk("bp.second.pc", 32'(id_pc), 32'h0012);
      chk("bp.second.occ", 32'(occupancy), 32'd1);
      cyc();
      chk("bp.empty.occ", 32'(occupancy), 32'd0);

      // hold
      offer(1'b1, 16'h0020, 16'h4444, 1'b0);
      cyc();
      hold_flag = 1'b1;
      offer(1'b0, 16'h0, 16'h0, 1'b0);
      cyc();
      chk("hold.inst", 32'(id_inst), 32'h4444);
      chk("hold.occ", 32'(occupancy), 32'd1);
      offer(1'b1, 16'h0022, 16'h5555, 1'b0);
      cyc();
      chk("hold.acc.occ", 32'(occupancy), 32'd2);
      chk("hold.acc.inst", 32'(id_inst), 32'h4444);
      hold_flag = 1'b0;
      offer(1'b0, 16'h0, 16'h0, 1'b0);
      cyc();
      chk("hold.rel.inst", 32'(id_inst), 32'h5555);
      cyc();
      chk("hold.rel.occ", 32'(occupancy), 32'd0);

      // flush in FULL overriding hold and a same-cycle offer
      id_ready = 1'b0;
      offer(1'b1, 16'h0030, 16'h6666, 1'b0);
      cyc();
      offer(1'b1, 16'h0032, 16'h7777, 1'b0);
      cyc();
      chk("fl.pre.occ", 32'(occupancy), 32'd2);
      flush = 1'b1; hold_flag = 1'b1; id_ready = 1'b1;
      offer(1'b1, 16'h0034, 16'h8888, 1'b0);
      cyc();
      chk("fl.occ", 32'(occupancy), 32'd0);
      chk("fl.valid", 32'(id_valid), 32'd0);
      chk("fl.inst", 32'(id_inst), 32'(NOP));
      chk("fl.if_ready", 32'(if_ready), 32'd1);
      flush = 1'b0; hold_flag = 1'b0;

      // fault tag
      id_ready = 1'b0;
      offer(1'b1, 16'h00A0, 16'h9999, 1'b1);
      cyc();
      chk("flt.head", 32'(id_fault), 32'd1);
      chk("flt.pc", 32'(id_pc), 32'h00A0);
      offer(1'b1, 16'h00A2, 16'hAAAA, 1'b0);
      cyc();
      chk("flt.full", 32'(id_fault), 32'd1);
      offer(1'b0, 16'h0, 16'h0, 1'b0);
      id_ready = 1'b1;
      cyc();
      chk("flt.next", 32'(id_fault), 32'd0);
      chk("flt.next.inst", 32'(id_inst), 32'hAAAA);

      // asynchronous reset while FULL
      id_ready = 1'b0;
      offer(1'b1, 16'h00B0, 16'hBBBB, 1'b1);
      cyc();
      chk("rf.pre.occ", 32'(occupancy), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("rf");
      offer(1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      offer(1'b1, 16'h00C0, 16'hCCCC, 1'b0);
      cyc();
      chk("first.valid", 32'(id_valid), 32'd1);
      chk("first.inst", 32'(id_inst), 32'hCCCC);
      chk("first.fault", 32'(id_fault), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
